// File: rtl/divider_if.sv
// Handshake and result bundle for the sequential divider.
// The master side issues a request; the slave side reports its status and results.
interface divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider.sv
// Unsigned restoring divider that produces one quotient bit per clock, MSB first.
// Results are registered on entry to DONE and held until the next completed division.
module divider #(
  parameter int WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] part_next;
  logic [WIDTH-1:0] quo_next;

  // work_q shifts dividend bits out of its MSB while quotient bits enter at its LSB
  always_comb begin
    shifted   = {part_q, work_q[WIDTH-1]};
    diff      = shifted - {1'b0, dvs_q};
    q_bit     = ~diff[WIDTH];
    part_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next  = {work_q[WIDTH-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    work_d  = work_q;
    part_d  = part_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.dividend;
          part_d  = '0;
          dvs_d   = bus.divisor;
          count_d = CW'(WIDTH - 1);
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        work_d  = quo_next;
        part_d  = part_next;
        count_d = count_q - CW'(1);
        if (count_q == '0) begin
          state_d = DONE;
          quo_d   = quo_next;
          rem_d   = part_next;
          dbz_d   = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      work_q  <= '0;
      part_q  <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      work_q  <= work_d;
      part_q  <= part_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed cases, random pairs and an exhaustive
// 4-bit sweep compared against plain integer division.
module tb_divider;

  localparam int WIDTH = 4;
  localparam int LIMIT = 3 * WIDTH + 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   lat;

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_r;

  divider_if #(.WIDTH(WIDTH)) bus ();

  divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Must be called at a falling edge with the divider idle; returns at the idle
  // falling edge right after the done pulse, ready for a back-to-back request.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_r;
    logic             exp_dbz;
    int               exp_lat;
    int               n;

    if (b == 0) begin
      exp_q   = '1;
      exp_r   = a;
      exp_dbz = 1'b1;
      exp_lat = 1;
    end else begin
      exp_q   = WIDTH'(int'(a) / int'(b));
      exp_r   = WIDTH'(int'(a) % int'(b));
      exp_dbz = 1'b0;
      exp_lat = WIDTH + 1;
    end

    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = WIDTH'($urandom);
    bus.divisor  = WIDTH'($urandom);
    n = 1;
    if (b != 0) begin
      checkOutput("busy_run", bus.busy, 1);
      checkOutput("hold_quotient_run", bus.quotient, prev_q);
      checkOutput("hold_remainder_run", bus.remainder, prev_r);
    end
    while (bus.done !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", n, exp_lat);
    checkOutput("quotient", bus.quotient, exp_q);
    checkOutput("remainder", bus.remainder, exp_r);
    checkOutput("div_by_zero", bus.div_by_zero, exp_dbz);
    prev_q = exp_q;
    prev_r = exp_r;

    @(negedge clk);
    checkOutput("done_single_pulse", bus.done, 0);
    checkOutput("busy_idle", bus.busy, 0);
    checkOutput("hold_quotient_idle", bus.quotient, exp_q);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    prev_q       = '0;
    prev_r       = '0;
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;

    // Reset state, with start ignored while reset is held
    #1;
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_done", bus.done, 0);
    checkOutput("reset_quotient", bus.quotient, 0);
    checkOutput("reset_remainder", bus.remainder, 0);
    checkOutput("reset_dbz", bus.div_by_zero, 0);
    @(posedge clk);
    #1;
    checkOutput("reset_ignores_start", bus.busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases; the first starts on the first edge after reset release
    applyStimulus(4'd13, 4'd3);
    applyStimulus(4'd7, 4'd0);
    applyStimulus(4'd2, 4'd9);
    applyStimulus(4'd15, 4'd1);
    applyStimulus(4'd0, 4'd0);
    applyStimulus(4'd15, 4'd15);

    // start held high while operands wander during RUN
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.done !== 1'b1) begin
        bus.dividend = WIDTH'($urandom);
        bus.divisor  = WIDTH'($urandom);
      end
    end while (bus.done !== 1'b1 && lat < LIMIT);
    checkOutput("held_start_latency", lat, WIDTH + 1);
    checkOutput("held_start_quotient", bus.quotient, 4);
    checkOutput("held_start_remainder", bus.remainder, 1);
    checkOutput("held_start_dbz", bus.div_by_zero, 0);
    prev_q       = 4'd4;
    prev_r       = 4'd1;
    bus.dividend = 4'd6;
    bus.divisor  = 4'd2;
    @(negedge clk);
    checkOutput("held_start_idle_gap", bus.busy, 0);
    applyStimulus(4'd6, 4'd2);

    // Reset asserted during the second RUN cycle aborts the division
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_quotient", bus.quotient, 0);
    checkOutput("abort_remainder", bus.remainder, 0);
    checkOutput("abort_dbz", bus.div_by_zero, 0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_no_done", bus.done, 0);
    checkOutput("abort_start_ignored", bus.busy, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    prev_q = '0;
    prev_r = '0;
    applyStimulus(4'd13, 4'd3);

    // Random operand pairs
    for (int i = 0; i < 24; i++) begin
      applyStimulus(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)));
    end

    // Exhaustive sweep of every operand pair
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(WIDTH'(a), WIDTH'(b));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand, quotient and remainder width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only while busy=0.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned numerator, captured on an accepted start.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned denominator, captured on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high while a division is in progress or completing.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse marking valid results.
REQ-009 SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-010 SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-011 SHALL have port div_by_zero, output, 1 bit: high with done when the captured divisor was 0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL capture dividend and divisor in IDLE when start=1 and enter RUN; start=0 in IDLE keeps IDLE.
REQ-014 SHALL ignore start while busy=1; captured operands and iteration are unaffected.
REQ-015 SHALL, in RUN, perform unsigned restoring division, one quotient bit per cycle, MSB first.
REQ-016 SHALL, each RUN cycle: shift {partial remainder, next dividend bit} left by 1; subtract divisor using a WIDTH+1-bit difference; keep the difference and set the quotient bit to 1 if it is non-negative, else restore and set the quotient bit to 0.
REQ-017 SHALL use a WIDTH-range iteration counter; RUN lasts exactly WIDTH cycles, then the FSM enters DONE.
REQ-018 SHALL hold DONE for exactly one cycle with done=1, then return to IDLE.
REQ-019 SHALL assert done exactly WIDTH+1 cycles after the clock edge that accepted start.
REQ-020 SHALL, on divisor=0: skip RUN, go IDLE->DONE, and set quotient to all ones, remainder to dividend and div_by_zero=1; done then asserts 1 cycle after acceptance.
REQ-021 SHALL assert busy in RUN and DONE, and deassert it in IDLE.
REQ-022 SHALL update quotient and remainder only on entry to DONE, holding them until the next completed division.
REQ-023 SHALL keep quotient and remainder outputs unaffected by intermediate RUN values.
REQ-024 SHALL hold div_by_zero until the next completed division.
REQ-025 SHALL accept a start asserted in the IDLE cycle immediately following DONE, giving back-to-back operation with one idle cycle minimum.
REQ-026 SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for all divisor != 0.

Reset
REQ-027 SHALL, when rst_n=0, asynchronously force the FSM to IDLE, clear the iteration counter and clear busy, done, quotient, remainder and div_by_zero to 0.
REQ-028 SHALL abort any division in progress when rst_n falls mid-RUN, with no done pulse produced for it.
REQ-029 SHALL ignore start while rst_n=0, and SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL cover: WIDTH=4, dividend=13, divisor=3, start for 1 cycle -> done at +5 cycles, quotient=4, remainder=1, div_by_zero=0.
REQ-031 SHALL cover: WIDTH=4, dividend=7, divisor=0 -> done at +1 cycle, quotient=15, remainder=7, div_by_zero=1.
REQ-032 SHALL cover: WIDTH=4, dividend=2, divisor=9 -> quotient=0, remainder=2; then dividend=15, divisor=1 -> quotient=15, remainder=0.
REQ-033 SHALL cover: start=1 held continuously with changing operands during RUN -> result reflects the first-captured operands only, and the next operation starts the cycle after DONE.
REQ-034 SHALL cover: rst_n pulsed low at RUN cycle 2 -> busy=0 and all outputs 0 immediately, with no done pulse; a fresh 13/3 then completes correctly.
REQ-035 SHALL cover: exhaustive WIDTH=4 sweep of all 256 operand pairs against a reference model, checking REQ-026 and latency.
